e161_resp_misr: RTL and testbench

- Downstream response-capture stage for the e161 control FSM.
- Samples the FSM's 17-bit Mealy output vector (y1..y17) over a programmed window and compacts it into a 17-bit MISR signature.
- Also keeps a per-output activity mask and two event counters.
- Used by the locking/verification flow to compare locked vs. oracle FSM responses with one signature compare instead of a per-cycle trace.

---
 rtl/e161_pkg.sv | 41 ++++
 rtl/e161_resp_misr_core.sv | 43 ++++
 rtl/e161_resp_misr.sv | 124 ++++++++++++
 tb/tb_e161_resp_misr.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e161_pkg.sv
// Shared constants, state encoding and helpers for the e161 response-capture path.
// Bit indices map FSM outputs y1..y17 onto the captured response vector.
package e161_pkg;

   localparam int W     = 17;
   localparam int LEN_W = 8;

   localparam int Y1_IDX  = 0;
   localparam int Y2_IDX  = 1;
   localparam int Y3_IDX  = 2;
   localparam int Y4_IDX  = 3;
   localparam int Y5_IDX  = 4;
   localparam int Y6_IDX  = 5;
   localparam int Y7_IDX  = 6;
   localparam int Y8_IDX  = 7;
   localparam int Y9_IDX  = 8;
   localparam int Y10_IDX = 9;
   localparam int Y11_IDX = 10;
   localparam int Y12_IDX = 11;
   localparam int Y13_IDX = 12;
   localparam int Y14_IDX = 13;
   localparam int Y15_IDX = 14;
   localparam int Y16_IDX = 15;
   localparam int Y17_IDX = 16;

   // x^17 + x^3 + 1; the x^17 term is implicit in the shift-out
   localparam logic [W-1:0] POLY_DEFAULT = 17'h00009;
   localparam logic [W-1:0] SEED_DEFAULT = 17'h00001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_t;

   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/e161_resp_misr_core.sv
// MISR signature register: GF(2) shift with polynomial feedback, XORed with the
// incoming response vector. Load restores the seed; enable absorbs one sample.
module misr_core #(
   parameter int           W    = 17,
   parameter logic [W-1:0] POLY = W'(9),
   parameter logic [W-1:0] SEED = W'(1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] data,
   output logic [W-1:0] sig
);

   logic [W-1:0] sig_reg;
   logic [W-1:0] sig_next;

   // The MSB leaves the register and is folded back through the tap mask.
   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign sig_next[gi] = (sig_reg[W-1] & POLY[gi]) ^ data[gi];
         end else begin : g_upper
            assign sig_next[gi] = sig_reg[gi-1] ^ (sig_reg[W-1] & POLY[gi]) ^ data[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_reg <= SEED;
      end else if (load) begin
         sig_reg <= SEED;
      end else if (en) begin
         sig_reg <= sig_next;
      end
   end

   assign sig = sig_reg;

endmodule

// File: rtl/e161_resp_misr.sv
// Response-capture stage: windows the e161 FSM output vector into a MISR
// signature, with a sticky activity mask and saturating idle/terminal counters.
module e161_resp_misr
   import e161_pkg::*;
#(
   parameter logic [W-1:0] POLY = POLY_DEFAULT,
   parameter logic [W-1:0] SEED = SEED_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] win_len,
   input  logic             abort,
   input  logic [W-1:0]     y_in,
   input  logic             y_valid,
   output logic             busy,
   output logic [W-1:0]     sig_out,
   output logic             sig_valid,
   output logic [W-1:0]     act_mask,
   output logic [LEN_W-1:0] idle_cnt,
   output logic [LEN_W-1:0] term_cnt
);

   cap_state_t       state_reg, state_next;
   logic [LEN_W-1:0] remaining_reg;
   logic [W-1:0]     mask_reg;
   logic [LEN_W-1:0] idle_cnt_reg;
   logic [LEN_W-1:0] term_cnt_reg;

   logic load;
   logic absorb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Abort outranks y_valid in CAPTURE, so a coincident final sample is dropped.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      absorb     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = (win_len != '0) ? ST_CAPTURE : ST_DONE;
            end
         end
         ST_ARM: begin
            state_next = ST_IDLE;
         end
         ST_CAPTURE: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (y_valid) begin
               absorb = 1'b1;
               if (remaining_reg <= LEN_W'(1)) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining_reg <= '0;
      end else if (load) begin
         remaining_reg <= win_len;
      end else if (absorb && remaining_reg != '0) begin
         remaining_reg <= remaining_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_reg     <= '0;
         idle_cnt_reg <= '0;
         term_cnt_reg <= '0;
      end else if (load) begin
         mask_reg     <= '0;
         idle_cnt_reg <= '0;
         term_cnt_reg <= '0;
      end else if (absorb) begin
         mask_reg <= mask_reg | y_in;
         if (y_in == '0) begin
            idle_cnt_reg <= sat_inc(idle_cnt_reg);
         end
         if (y_in[Y17_IDX]) begin
            term_cnt_reg <= sat_inc(term_cnt_reg);
         end
      end
   end

   misr_core #(
      .W    (W),
      .POLY (POLY),
      .SEED (SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .en   (absorb),
      .data (y_in),
      .sig  (sig_out)
   );

   assign busy      = (state_reg == ST_CAPTURE) || (state_reg == ST_ARM);
   assign sig_valid = (state_reg == ST_DONE);
   assign act_mask  = mask_reg;
   assign idle_cnt  = idle_cnt_reg;
   assign term_cnt  = term_cnt_reg;

endmodule

// File: tb/tb_e161_resp_misr.sv
// Directed bench for e161_resp_misr: inputs driven and outputs sampled on the
// falling edge, midway between the rising edges that update the design.
module tb_e161_resp_misr;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  win_len;
   logic        abort;
   logic [16:0] y_in;
   logic        y_valid;
   logic        busy;
   logic [16:0] sig_out;
   logic        sig_valid;
   logic [16:0] act_mask;
   logic [7:0]  idle_cnt;
   logic [7:0]  term_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;

   e161_resp_misr dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .win_len   (win_len),
      .abort     (abort),
      .y_in      (y_in),
      .y_valid   (y_valid),
      .busy      (busy),
      .sig_out   (sig_out),
      .sig_valid (sig_valid),
      .act_mask  (act_mask),
      .idle_cnt  (idle_cnt),
      .term_cnt  (term_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] misr_step(input logic [16:0] s, input logic [16:0] y);
      return {s[15:0], 1'b0} ^ (s[16] ? 17'h00009 : 17'h00000) ^ y;
   endfunction

   task automatic open_window(input logic [7:0] len);
      start   = 1'b1;
      win_len = len;
      @(negedge clk);
      start   = 1'b0;
      win_len = 8'hA5;
   endtask

   task automatic sample(input logic [16:0] v);
      y_valid = 1'b1;
      y_in    = v;
      @(negedge clk);
      y_valid = 1'b0;
      y_in    = 17'h1ABCD;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; win_len = 8'd0; abort = 1'b0; y_in = 17'h0; y_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0 || sig_valid !== 1'b0) begin
         $display("FAIL reset_flags: busy=%b sig_valid=%b want 0 0", busy, sig_valid);
      end else pass_cnt++;
      total_cnt++;
      if (sig_out !== 17'h00001 || act_mask !== 17'h0) begin
         $display("FAIL reset_sig: sig=%h mask=%h want 00001 00000", sig_out, act_mask);
      end else pass_cnt++;
      total_cnt++;
      if (idle_cnt !== 8'd0 || term_cnt !== 8'd0) begin
         $display("FAIL reset_cnt: idle=%0d term=%0d want 0 0", idle_cnt, term_cnt);
      end else pass_cnt++;
      $display("reset: sig=%h busy=%b", sig_out, busy);
   endtask

   task automatic test_basic;
      open_window(8'd2);
      total_cnt++;
      if (busy !== 1'b1 || sig_out !== 17'h00001) begin
         $display("FAIL basic_start: busy=%b sig=%h want 1 00001", busy, sig_out);
      end else pass_cnt++;
      sample(17'h00000);
      total_cnt++;
      if (sig_out !== 17'h00002 || sig_valid !== 1'b0) begin
         $display("FAIL basic_s1: sig=%h vld=%b want 00002 0", sig_out, sig_valid);
      end else pass_cnt++;
      sample(17'h00001);
      total_cnt++;
      if (sig_out !== 17'h00005 || sig_valid !== 1'b1) begin
         $display("FAIL basic_s2: sig=%h vld=%b want 00005 1", sig_out, sig_valid);
      end else pass_cnt++;
      total_cnt++;
      if (idle_cnt !== 8'd1 || act_mask !== 17'h00001 || term_cnt !== 8'd0) begin
         $display("FAIL basic_stats: idle=%0d mask=%h term=%0d want 1 00001 0", idle_cnt, act_mask, term_cnt);
      end else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (sig_valid !== 1'b0 || busy !== 1'b0 || sig_out !== 17'h00005) begin
         $display("FAIL basic_after: vld=%b busy=%b sig=%h want 0 0 00005", sig_valid, busy, sig_out);
      end else pass_cnt++;
      $display("basic window: sig=%h mask=%h idle=%0d", sig_out, act_mask, idle_cnt);
   endtask

   task automatic test_feedback_wrap;
      logic [16:0] exp_sig, exp_mask, v;
      logic [7:0]  exp_idle, exp_term;
      open_window(8'd17);
      for (int i = 0; i < 16; i++) sample(17'h00000);
      total_cnt++;
      if (sig_out !== 17'h10000) begin
         $display("FAIL wrap_pre: sig=%h want 10000", sig_out);
      end else pass_cnt++;
      sample(17'h00000);
      total_cnt++;
      if (sig_out !== 17'h00009 || sig_valid !== 1'b1 || idle_cnt !== 8'd17) begin
         $display("FAIL wrap_post: sig=%h vld=%b idle=%0d want 00009 1 17", sig_out, sig_valid, idle_cnt);
      end else pass_cnt++;
      @(negedge clk);
      // second window of mixed patterns checked against the bench model
      exp_sig = 17'h00001; exp_mask = '0; exp_idle = '0; exp_term = '0;
      open_window(8'd17);
      for (int i = 0; i < 17; i++) begin
         v = 17'(i * 13'h1357) ^ ((i % 3 == 0) ? 17'h10000 : 17'h00000);
         if (i == 5) v = 17'h00000;
         exp_sig  = misr_step(exp_sig, v);
         exp_mask = exp_mask | v;
         if (v == 17'h0) exp_idle++;
         if (v[16]) exp_term++;
         sample(v);
      end
      total_cnt++;
      if (sig_out !== exp_sig || sig_valid !== 1'b1) begin
         $display("FAIL wrap_model_sig: sig=%h vld=%b want %h 1", sig_out, sig_valid, exp_sig);
      end else pass_cnt++;
      total_cnt++;
      if (act_mask !== exp_mask || idle_cnt !== exp_idle || term_cnt !== exp_term) begin
         $display("FAIL wrap_model_stats: mask=%h idle=%0d term=%0d want %h %0d %0d",
                  act_mask, idle_cnt, term_cnt, exp_mask, exp_idle, exp_term);
      end else pass_cnt++;
      @(negedge clk);
      $display("feedback window: sig=%h mask=%h", exp_sig, exp_mask);
   endtask

   task automatic test_stretch;
      int cycles = 0;
      open_window(8'd3);
      for (int k = 0; k < 20 && busy === 1'b1; k++) begin
         y_valid = (k % 2 == 0);
         y_in    = 17'h10000;
         cycles++;
         @(negedge clk);
      end
      y_valid = 1'b0;
      total_cnt++;
      if (cycles != 5 || sig_valid !== 1'b1) begin
         $display("FAIL stretch_len: cycles=%0d vld=%b want 5 1", cycles, sig_valid);
      end else pass_cnt++;
      total_cnt++;
      if (sig_out !== 17'h10013 || term_cnt !== 8'd3 || act_mask !== 17'h10000 || idle_cnt !== 8'd0) begin
         $display("FAIL stretch_res: sig=%h term=%0d mask=%h idle=%0d want 10013 3 10000 0",
                  sig_out, term_cnt, act_mask, idle_cnt);
      end else pass_cnt++;
      @(negedge clk);
      $display("stretch window: cycles=%0d sig=%h", cycles, sig_out);
   endtask

   task automatic test_abort;
      open_window(8'd2);
      sample(17'h00000);
      abort = 1'b1;
      sample(17'h00003);
      abort = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || sig_valid !== 1'b0 || sig_out !== 17'h00002) begin
         $display("FAIL abort_last: busy=%b vld=%b sig=%h want 0 0 00002", busy, sig_valid, sig_out);
      end else pass_cnt++;
      total_cnt++;
      if (idle_cnt !== 8'd1 || act_mask !== 17'h0) begin
         $display("FAIL abort_stats: idle=%0d mask=%h want 1 00000", idle_cnt, act_mask);
      end else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (sig_valid !== 1'b0) begin
         $display("FAIL abort_novalid: vld=%b want 0", sig_valid);
      end else pass_cnt++;
      $display("abort window: sig=%h", sig_out);
   endtask

   task automatic test_zero_len_and_restart;
      open_window(8'd0);
      total_cnt++;
      if (sig_valid !== 1'b1 || sig_out !== 17'h00001 || busy !== 1'b0) begin
         $display("FAIL zero_len: vld=%b sig=%h busy=%b want 1 00001 0", sig_valid, sig_out, busy);
      end else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (sig_valid !== 1'b0) begin
         $display("FAIL zero_len_pulse: vld=%b want 0", sig_valid);
      end else pass_cnt++;
      open_window(8'd3);
      sample(17'h00001);
      open_window(8'd5);
      total_cnt++;
      if (busy !== 1'b1 || sig_out !== 17'h00003) begin
         $display("FAIL restart_ignored: busy=%b sig=%h want 1 00003", busy, sig_out);
      end else pass_cnt++;
      sample(17'h00000);
      sample(17'h00000);
      total_cnt++;
      if (sig_valid !== 1'b1 || sig_out !== 17'h0000C || idle_cnt !== 8'd2 || act_mask !== 17'h00001) begin
         $display("FAIL restart_end: vld=%b sig=%h idle=%0d mask=%h want 1 0000c 2 00001",
                  sig_valid, sig_out, idle_cnt, act_mask);
      end else pass_cnt++;
      @(negedge clk);
      $display("zero-length and restart-ignore windows: sig=%h", sig_out);
   endtask

   task automatic test_saturation;
      logic [16:0] exp_sig = 17'h00001;
      open_window(8'd255);
      for (int i = 0; i < 255; i++) begin
         exp_sig = misr_step(exp_sig, 17'h0);
         sample(17'h00000);
      end
      total_cnt++;
      if (idle_cnt !== 8'd255 || sig_valid !== 1'b1 || sig_out !== exp_sig) begin
         $display("FAIL sat_idle: idle=%0d vld=%b sig=%h want 255 1 %h", idle_cnt, sig_valid, sig_out, exp_sig);
      end else pass_cnt++;
      @(negedge clk);
      $display("saturation window: idle=%0d sig=%h", idle_cnt, sig_out);
   endtask

   task automatic test_async_reset;
      int bad_valid = 0;
      open_window(8'd10);
      sample(17'h10001);
      sample(17'h00F00);
      sample(17'h00000);
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if (busy !== 1'b0 || sig_valid !== 1'b0 || sig_out !== 17'h00001) begin
         $display("FAIL arst_flags: busy=%b vld=%b sig=%h want 0 0 00001", busy, sig_valid, sig_out);
      end else pass_cnt++;
      total_cnt++;
      if (act_mask !== 17'h0 || idle_cnt !== 8'd0 || term_cnt !== 8'd0) begin
         $display("FAIL arst_stats: mask=%h idle=%0d term=%0d want 00000 0 0", act_mask, idle_cnt, term_cnt);
      end else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         y_valid = 1'b1;
         y_in    = 17'h00000;
         @(negedge clk);
         if (sig_valid !== 1'b0 || busy !== 1'b0) bad_valid++;
      end
      y_valid = 1'b0;
      total_cnt++;
      if (bad_valid != 0) begin
         $display("FAIL arst_quiet: bad_cycles=%0d want 0", bad_valid);
      end else pass_cnt++;
      $display("async reset: sig=%h busy=%b", sig_out, busy);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_feedback_wrap();
      test_stretch();
      test_abort();
      test_zero_len_and_restart();
      test_saturation();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
